// File: rtl/timestamp_readout_if.sv
// Byte stream from the timestamp readout toward the USB FIFO writer.
// One byte moves on every cycle where oValid && iReady.
interface timestamp_readout_if;
    logic [7:0] oData;
    logic       oValid;
    logic       iReady;

    modport master (output oData, output oValid, input iReady);
    modport slave  (input oData, input oValid, output iReady);
endinterface

// File: rtl/timestamp_readout.sv
// Timestamp readout: waits for a latch channel to report ready, takes a
// consistent snapshot of its 96-bit counter, streams it as a 14-byte framed
// packet and runs the per-channel reset-latch handshake.

// Per-channel control: ready synchronizer plus reset-latch level handshake.
module ts_chan_ctl #(
    parameter int pSYNC_STAGES = 2
) (
    input  logic globalClock,
    input  logic iReset_n,
    input  logic rdy_i,        // raw ready level from the latch domain
    input  logic served_i,     // pulse: packet for this channel is committed
    output logic rdy_s_o,      // synchronized ready
    output logic rst_latch_o   // read-done toward the latch
);
    logic [pSYNC_STAGES-1:0] sync_q;
    logic                    rl_q, rl_d;

    // Shift the asynchronous ready level through the synchronizer chain.
    always_ff @(posedge globalClock or negedge iReset_n) begin
        if (!iReset_n) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= rdy_i;
            for (int i = 1; i < pSYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign rdy_s_o = sync_q[pSYNC_STAGES-1];

    // Read-done is raised when the packet is committed and held until the
    // latch has visibly dropped its ready, so one event yields one packet.
    always_comb begin
        rl_d = rl_q;
        if (served_i)
            rl_d = 1'b1;
        else if (rl_q && !rdy_s_o)
            rl_d = 1'b0;
    end

    // Read-done register.
    always_ff @(posedge globalClock or negedge iReset_n) begin
        if (!iReset_n) rl_q <= 1'b0;
        else           rl_q <= rl_d;
    end

    assign rst_latch_o = rl_q;
endmodule

module timestamp_readout #(
    parameter int pSYNC_STAGES = 2,
    parameter int pMAX_RETRY   = 3
) (
    input  logic                 globalClock,
    input  logic                 iReset_n,
    input  logic                 iRdy1,
    input  logic [31:0]          i1Lo,
    input  logic [31:0]          i1Hi,
    input  logic [31:0]          i1Phase,
    input  logic                 iRdy2,
    input  logic [31:0]          i2Lo,
    input  logic [31:0]          i2Hi,
    input  logic [31:0]          i2Phase,
    output logic                 oResetLatch1,
    output logic                 oResetLatch2,
    timestamp_readout_if.master  stream,
    output logic                 oBusy,
    output logic [7:0]           oErrCount
);
    localparam int NUM_CH    = 2;
    localparam int WORD_W    = 96;                 // {Phase, Hi, Lo}
    localparam int PKT_W     = 112;                // 14 bytes
    localparam int RW        = $clog2(pMAX_RETRY + 1);
    localparam logic [RW-1:0] MAX_R    = RW'(pMAX_RETRY);
    localparam logic [3:0]    LAST_IDX = 4'd13;

    typedef enum logic [1:0] {IDLE, SNAP1, SNAP2, SEND} state_t;

    logic [NUM_CH-1:0]             rdy_raw, rdy_s, rst_latch, served, elig;
    logic [NUM_CH-1:0][WORD_W-1:0] ch_words;
    logic [WORD_W-1:0]             cur_words;

    state_t              state_q, state_d;
    logic                sel_q, sel_d;        // 0 = channel 1, 1 = channel 2
    logic                last_q, last_d;      // channel served most recently
    logic [RW-1:0]       retry_q, retry_d;
    logic [WORD_W-1:0]   snap_a_q, snap_a_d;
    logic [PKT_W-1:0]    pkt_q, pkt_d;        // byte 0 sits in [7:0], shifts out
    logic [3:0]          idx_q, idx_d;
    logic [7:0]          err_cnt_q, err_cnt_d;
    logic                enter_send, pkt_err;

    assign rdy_raw     = {iRdy2, iRdy1};
    assign ch_words[0] = {i1Phase, i1Hi, i1Lo};
    assign ch_words[1] = {i2Phase, i2Hi, i2Lo};

    genvar g;
    generate
        for (g = 0; g < NUM_CH; g++) begin : g_ch
            ts_chan_ctl #(.pSYNC_STAGES(pSYNC_STAGES)) u_ch (
                .globalClock (globalClock),
                .iReset_n    (iReset_n),
                .rdy_i       (rdy_raw[g]),
                .served_i    (served[g]),
                .rdy_s_o     (rdy_s[g]),
                .rst_latch_o (rst_latch[g])
            );
        end
    endgenerate

    // A channel still holding read-done has already been served for this event.
    assign elig      = rdy_s & ~rst_latch;
    assign cur_words = ch_words[sel_q];

    // Frame: header, Lo, Hi, Phase (each LSB first), XOR checksum last.
    function automatic logic [PKT_W-1:0] build_pkt(input logic err,
                                                   input logic ch,
                                                   input logic [WORD_W-1:0] w);
        logic [7:0]   hdr;
        logic [7:0]   chk;
        logic [103:0] body;
        hdr  = {4'hA, err, 2'b00, ch};
        body = {w, hdr};
        chk  = '0;
        for (int i = 0; i < 13; i++) chk = chk ^ body[i*8 +: 8];
        return {chk, body};
    endfunction

    // Next-state logic: arbitration, double-read snapshot, byte streaming.
    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        last_d     = last_q;
        retry_d    = retry_q;
        snap_a_d   = snap_a_q;
        pkt_d      = pkt_q;
        idx_d      = idx_q;
        err_cnt_d  = err_cnt_q;
        served     = '0;
        enter_send = 1'b0;
        pkt_err    = 1'b0;

        case (state_q)
            IDLE: begin
                if (|elig) begin
                    // Both pending: take the one not served last time.
                    sel_d   = (&elig) ? ~last_q : elig[1];
                    state_d = SNAP1;
                end
            end
            SNAP1: begin
                snap_a_d = cur_words;
                state_d  = SNAP2;
            end
            SNAP2: begin
                // The second read is the payload; it equals the first when stable.
                if (cur_words == snap_a_q) begin
                    enter_send = 1'b1;
                end else if (retry_q < MAX_R) begin
                    retry_d = retry_q + 1'b1;
                    state_d = SNAP1;
                end else begin
                    enter_send = 1'b1;
                    pkt_err    = 1'b1;
                    if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
                end
                if (enter_send) begin
                    state_d       = SEND;
                    served[sel_q] = 1'b1;
                    last_d        = sel_q;
                    retry_d       = '0;
                    idx_d         = '0;
                    pkt_d         = build_pkt(pkt_err, sel_q, cur_words);
                end
            end
            SEND: begin
                if (stream.iReady) begin
                    pkt_d = pkt_q >> 8;
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = IDLE;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any packet in flight.
    always_ff @(posedge globalClock or negedge iReset_n) begin
        if (!iReset_n) begin
            state_q   <= IDLE;
            sel_q     <= 1'b0;
            last_q    <= 1'b1;
            retry_q   <= '0;
            snap_a_q  <= '0;
            pkt_q     <= '0;
            idx_q     <= '0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            last_q    <= last_d;
            retry_q   <= retry_d;
            snap_a_q  <= snap_a_d;
            pkt_q     <= pkt_d;
            idx_q     <= idx_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    // Stream outputs come straight from the state, so oValid and oData hold
    // through a stall and fall together the cycle after the final byte.
    assign stream.oValid = (state_q == SEND);
    assign stream.oData  = (state_q == SEND) ? pkt_q[7:0] : 8'h00;

    assign oBusy        = (state_q != IDLE);
    assign oErrCount    = err_cnt_q;
    assign oResetLatch1 = rst_latch[0];
    assign oResetLatch2 = rst_latch[1];
endmodule
